// File: rtl/tile_map_keeper.sv
// Playfield tile map: streams a level layout out of a synchronous ROM, then
// applies the bullet-hit tile changes reported by both tanks.
module tile_map_keeper #(
  parameter int MAP_TILES  = 300,
  parameter int NUM_LEVELS = 4,
  parameter int ROM_AW     = 11
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               restart,
  input  logic [1:0]         level,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [2:0]         rom_data,
  input  logic signed [31:0] change1,
  input  logic signed [31:0] change2,
  output logic [31:0]        map [MAP_TILES],
  output logic               ready,
  output logic [8:0]         bricks_left
);
  localparam int IW = $clog2(MAP_TILES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(MAP_TILES);

  typedef enum logic {LOAD, RUN} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg;
  logic [1:0]    lvl_reg;
  logic [1:0]    level_sel;
  logic [8:0]    bricks_reg;

  logic          load_we;
  logic [IW-1:0] wr_ptr;
  logic [2:0]    load_code;
  logic          run_go;
  logic          v1, v2;
  logic [IW-1:0] i1, i2;
  logic [2:0]    code1, code2;
  logic          dec1, dec2;
  logic [8:0]    dec;

  function automatic logic [2:0] hit_code(input logic [2:0] c);
    case (c)
      3'd2, 3'd6: hit_code = 3'd0;
      3'd5:       hit_code = 3'd2;
      default:    hit_code = c;
    endcase
  endfunction

  assign level_sel = (int'(level) >= NUM_LEVELS) ? 2'(NUM_LEVELS - 1) : level;

  // State register
  always_ff @(posedge frame_clk) begin
    if (!Reset) state_reg <= LOAD;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD: if (idx_reg == LAST_IDX) state_next = RUN;
      RUN:  if (restart)             state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Outputs; the address bus is parked at 0 outside an active sweep
  always_comb begin
    ready    = (state_reg == RUN);
    rom_addr = '0;
    if (Reset && state_reg == LOAD && idx_reg != LAST_IDX)
      rom_addr = ROM_AW'(ROM_AW'(lvl_reg) * ROM_AW'(MAP_TILES)) + ROM_AW'(idx_reg);
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      idx_reg <= '0;
      lvl_reg <= level_sel;
    end else if (state_reg == LOAD) begin
      if (idx_reg != LAST_IDX) idx_reg <= idx_reg + 1'b1;
    end else if (restart) begin
      idx_reg <= '0;
      lvl_reg <= level_sel;
    end
  end

  // ROM data lags its address by one cycle, so the write trails the sweep by one tile
  assign load_we   = (state_reg == LOAD) && (idx_reg != '0);
  assign wr_ptr    = idx_reg - 1'b1;
  assign load_code = (rom_data == 3'd7) ? 3'd1 : rom_data;
  assign run_go    = (state_reg == RUN) && !restart;

  always_comb begin
    v1    = (change1 > 0) && (change1 < MAP_TILES);
    v2    = (change2 > 0) && (change2 < MAP_TILES);
    i1    = v1 ? change1[IW-1:0] : '0;
    i2    = v2 ? change2[IW-1:0] : '0;
    code1 = map[i1][2:0];
    code2 = map[i2][2:0];
    dec1  = v1 && (code1 == 3'd2);
    // A duplicate index is only counted once
    dec2  = v2 && !(v1 && i1 == i2) && (code2 == 3'd2);
    dec   = {8'd0, dec1} + {8'd0, dec2};
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      bricks_reg <= '0;
    end else if (state_reg == LOAD) begin
      if (load_we && (load_code == 3'd2 || load_code == 3'd5))
        bricks_reg <= bricks_reg + 1'b1;
    end else if (restart) begin
      bricks_reg <= '0;
    end else begin
      bricks_reg <= (bricks_reg > dec) ? bricks_reg - dec : '0;
    end
  end

  assign bricks_left = bricks_reg;

  genvar gi;
  generate
    for (gi = 0; gi < MAP_TILES; gi++) begin : g_tile
      localparam logic [IW-1:0] TILE_IDX = IW'(gi);
      logic [2:0] tile_reg;
      logic       hit;

      assign hit = (v1 && i1 == TILE_IDX) || (v2 && i2 == TILE_IDX);

      always_ff @(posedge frame_clk) begin
        if (!Reset)
          tile_reg <= 3'd1;
        else if (load_we && wr_ptr == TILE_IDX)
          tile_reg <= load_code;
        else if (run_go && hit)
          tile_reg <= hit_code(tile_reg);
      end

      assign map[gi] = {29'd0, tile_reg};
    end
  endgenerate
endmodule

// File: tb/tb_tile_map_keeper.sv
// Directed bench for tile_map_keeper: level loads, hit rules, restart and
// mid-load reset, checked against hand-computed values.
module tb_tile_map_keeper;
  logic        frame_clk = 1'b0;
  logic        Reset = 1'b0;
  logic        restart = 1'b0;
  logic [1:0]  level = 2'd0;
  logic [10:0] rom_addr;
  logic [2:0]  rom_data = 3'd0;
  int          change1 = 0;
  int          change2 = 0;
  logic [31:0] map [300];
  logic        ready;
  logic [8:0]  bricks_left;

  logic [2:0]  rom [2048];
  int          checks = 0;
  int          failures = 0;

  tile_map_keeper dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .restart     (restart),
    .level       (level),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .change1     (change1),
    .change2     (change2),
    .map         (map),
    .ready       (ready),
    .bricks_left (bricks_left)
  );

  always #5 frame_clk = ~frame_clk;

  always @(posedge frame_clk) rom_data <= rom[rom_addr];

  // Level 2 uses i%8 so raw code 7 appears; other levels use i%7
  function automatic int raw_tile(input int lvl, input int i);
    return (lvl == 2) ? (i % 8) : (i % 7);
  endfunction

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic map_errors(input int lvl, output int bad);
    int e;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      e = raw_tile(lvl, i);
      if (e == 7) e = 1;
      if (map[i] != 32'(e)) bad++;
    end
  endtask

  task automatic apply(input int c1, input int c2);
    change1 = c1;
    change2 = c2;
    @(negedge frame_clk);
    change1 = 0;
    change2 = 0;
    $display("req c1=%0d c2=%0d bricks=%0d", c1, c2, bricks_left);
  endtask

  task automatic run_load(input int base, input int cycles, input bit inject);
    int addr_bad;
    int rdy_bad;
    int exp_addr;
    addr_bad = 0;
    rdy_bad  = 0;
    for (int k = 0; k < cycles; k++) begin
      exp_addr = (k < 300) ? base + k : 0;
      if (rom_addr !== 11'(exp_addr)) addr_bad++;
      if (ready !== 1'b0) rdy_bad++;
      if (inject) begin
        if (k == 5) begin restart = 1'b1; level = 2'd3; end
        if (k == 6) restart = 1'b0;
        if (k == 20) change1 = 10;
        if (k == 21) begin
          change1 = 0;
          check_val("load_drop_map10", int'(map[10]), 2);
        end
      end
      @(negedge frame_clk);
    end
    $display("load base=%0d cycles=%0d addr_bad=%0d ready_bad=%0d", base, cycles, addr_bad, rdy_bad);
    check_val("rom_sweep", addr_bad, 0);
    check_val("ready_low_in_load", rdy_bad, 0);
  endtask

  initial begin
    int bad;
    for (int a = 0; a < 2048; a++)
      rom[a] = (a < 1200) ? 3'(raw_tile(a / 300, a % 300)) : 3'd0;

    // Reset
    Reset = 1'b0;
    level = 2'd1;
    repeat (2) @(negedge frame_clk);
    check_val("rst_ready", int'(ready), 0);
    check_val("rst_rom_addr", int'(rom_addr), 0);
    check_val("rst_bricks", int'(bricks_left), 0);
    check_val("rst_map0", int'(map[0]), 1);
    check_val("rst_map299", int'(map[299]), 1);

    // Level 1 load
    Reset = 1'b1;
    #1;
    run_load(300, 301, 1'b0);
    check_val("l1_ready", int'(ready), 1);
    map_errors(1, bad);
    check_val("l1_map", bad, 0);
    check_val("l1_bricks", int'(bricks_left), 86);

    // Change rules
    apply(44, 0);
    check_val("brick44", int'(map[44]), 0);
    check_val("brick44_cnt", int'(bricks_left), 85);
    apply(44, 0);
    check_val("brick44_again", int'(map[44]), 0);
    check_val("brick44_again_cnt", int'(bricks_left), 85);
    apply(61, 61);
    check_val("armored61_dup", int'(map[61]), 2);
    check_val("armored61_dup_cnt", int'(bricks_left), 85);
    apply(0, 61);
    check_val("armored61_second", int'(map[61]), 0);
    check_val("armored61_second_cnt", int'(bricks_left), 84);
    apply(23, 27);
    check_val("pair_brick23", int'(map[23]), 0);
    check_val("pair_bush27", int'(map[27]), 0);
    check_val("pair_cnt", int'(bricks_left), 83);
    apply(30, 37);
    check_val("two_bricks30", int'(map[30]), 0);
    check_val("two_bricks37", int'(map[37]), 0);
    check_val("two_bricks_cnt", int'(bricks_left), 81);
    apply(0, 300);
    check_val("ign_map0", int'(map[0]), 0);
    check_val("ign_300_cnt", int'(bricks_left), 81);
    apply(-1, 1);
    check_val("ign_steel1", int'(map[1]), 1);
    apply(3, 4);
    check_val("ign_base3", int'(map[3]), 3);
    check_val("ign_base4", int'(map[4]), 4);
    check_val("ign_cnt", int'(bricks_left), 81);
    apply(299, 0);
    check_val("armored299", int'(map[299]), 2);
    check_val("armored299_cnt", int'(bricks_left), 81);

    // Restart with a simultaneous request
    level   = 2'd2;
    restart = 1'b1;
    change1 = 51;
    @(negedge frame_clk);
    restart = 1'b0;
    change1 = 0;
    check_val("restart_ready", int'(ready), 0);
    check_val("restart_map51", int'(map[51]), 2);
    run_load(600, 301, 1'b1);
    check_val("l2_ready", int'(ready), 1);
    map_errors(2, bad);
    check_val("l2_map", bad, 0);
    check_val("l2_code7", int'(map[7]), 1);
    check_val("l2_bricks", int'(bricks_left), 75);

    // Reset in the middle of a load
    level   = 2'd3;
    restart = 1'b1;
    @(negedge frame_clk);
    restart = 1'b0;
    run_load(900, 150, 1'b0);
    Reset = 1'b0;
    level = 2'd1;
    @(negedge frame_clk);
    check_val("midrst_ready", int'(ready), 0);
    check_val("midrst_rom_addr", int'(rom_addr), 0);
    check_val("midrst_bricks", int'(bricks_left), 0);
    check_val("midrst_map0", int'(map[0]), 1);
    Reset = 1'b1;
    #1;
    run_load(300, 301, 1'b0);
    check_val("reload_ready", int'(ready), 1);
    map_errors(1, bad);
    check_val("reload_map", bad, 0);
    check_val("reload_bricks", int'(bricks_left), 86);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
